wta_pwm_ctrl: RTL and testbench

Winner-take-all PWM controller for the WTA PWM tile: every PWM period it scans N_CH analog-derived level words sequentially, elects one winning channel with hysteresis, and drives a single PWM output on that channel's line with duty equal to its level. It sits between the level-capture logic fed from `ui_in` and the `uo_out` pin mux.

---
 rtl/wta_pwm_ctrl_pkg.sv | 19 +
 rtl/wta_pwm_gen.sv | 32 +++
 rtl/wta_pwm_ctrl.sv | 162 ++++++++++++++++
 tb/tb_wta_pwm_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wta_pwm_ctrl_pkg.sv
// Shared types and defaults for the winner-take-all PWM controller.
package wta_pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int unsigned N_CH_DEF = 4;
    localparam int unsigned W_DEF    = 8;
    localparam int unsigned HYST_DEF = 8;

    // Width of a channel index; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wta_pwm_gen.sv
// PWM run counter: W-bit counter active only during RUN, duty compare,
// first/last-count flags decoded from the counter register.
module wta_pwm_gen #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run,
    input  logic [W-1:0] duty,
    output logic         pwm_on,
    output logic         cnt_first,
    output logic         cnt_last
);

    logic [W-1:0] cnt;

    // Count through the RUN interval; held at zero otherwise so each RUN starts at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + W'(1);
        end else begin
            cnt <= '0;
        end
    end

    assign pwm_on    = run && (cnt < duty);
    assign cnt_first = run && (cnt == '0);
    assign cnt_last  = run && (cnt == '1);

endmodule

// File: rtl/wta_pwm_ctrl.sv
// Winner-take-all PWM controller: sequential level scan, hysteretic election,
// single-channel PWM drive of the elected winner.
module wta_pwm_ctrl
    import wta_pwm_pkg::*;
#(
    parameter int unsigned N_CH = N_CH_DEF,
    parameter int unsigned W    = W_DEF,
    parameter int unsigned HYST = HYST_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic [N_CH*W-1:0]          level,
    output logic [N_CH-1:0]            pwm_o,
    output logic [idx_width(N_CH)-1:0] winner_o,
    output logic                       win_valid_o,
    output logic                       period_o
);

    localparam int unsigned IW       = idx_width(N_CH);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_CH - 1);
    localparam logic [W:0]    HYST_EXT = (W + 1)'(HYST);

    state_t       state, state_n;
    logic [IW-1:0] idx;
    logic [IW-1:0] winner;
    logic [IW-1:0] cand_idx;
    logic [W-1:0]  cand_lvl;
    logic [W-1:0]  cur_lvl;
    logic [W-1:0]  duty;
    logic          valid;

    logic [W-1:0]  lv [N_CH];
    logic [W-1:0]  smp;
    logic          scan_last;
    logic [IW-1:0] nxt_idx;
    logic [W-1:0]  nxt_lvl;
    logic [W-1:0]  nxt_cur;
    logic [IW-1:0] elect_idx;
    logic [W-1:0]  elect_duty;

    logic          run;
    logic          pwm_on;
    logic          cnt_first;
    logic          cnt_last;

    // Unpack the level bus into per-channel words.
    always_comb begin
        for (int unsigned k = 0; k < N_CH; k++) begin
            lv[k] = level[k*W +: W];
        end
    end

    assign smp       = lv[idx];
    assign scan_last = (state == SCAN) && (idx == IDX_LAST);
    assign run       = (state == RUN);

    // Running candidate including this cycle's sample; index 0 always seeds it.
    always_comb begin
        nxt_idx = cand_idx;
        nxt_lvl = cand_lvl;
        if (idx == '0 || smp > cand_lvl) begin
            nxt_idx = idx;
            nxt_lvl = smp;
        end
        nxt_cur = (idx == winner) ? smp : cur_lvl;
    end

    // Election applied on the final scan cycle; margin compare is one bit wider to avoid wrap.
    always_comb begin
        elect_idx  = winner;
        elect_duty = nxt_cur;
        if (!valid) begin
            elect_idx  = nxt_idx;
            elect_duty = nxt_lvl;
        end else if (nxt_idx != winner &&
                     {1'b0, nxt_lvl} > ({1'b0, nxt_cur} + HYST_EXT)) begin
            elect_idx  = nxt_idx;
            elect_duty = nxt_lvl;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; ena only matters in IDLE and on the last RUN count.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (ena) state_n = SCAN;
            SCAN:    if (scan_last) state_n = RUN;
            RUN:     if (cnt_last) state_n = ena ? SCAN : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Scan index, candidate tracking, election results and validity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            winner   <= '0;
            cand_idx <= '0;
            cand_lvl <= '0;
            cur_lvl  <= '0;
            duty     <= '0;
            valid    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    idx <= '0;
                end
                SCAN: begin
                    cand_idx <= nxt_idx;
                    cand_lvl <= nxt_lvl;
                    cur_lvl  <= nxt_cur;
                    if (scan_last) begin
                        idx    <= '0;
                        winner <= elect_idx;
                        duty   <= elect_duty;
                        valid  <= 1'b1;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                RUN: begin
                    idx <= '0;
                    if (cnt_last && !ena) valid <= 1'b0;
                end
                default: idx <= '0;
            endcase
        end
    end

    wta_pwm_gen #(
        .W (W)
    ) u_gen (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .duty      (duty),
        .pwm_on    (pwm_on),
        .cnt_first (cnt_first),
        .cnt_last  (cnt_last)
    );

    // Route the PWM level onto the winner's line only.
    always_comb begin
        pwm_o = '0;
        if (pwm_on) pwm_o[winner] = 1'b1;
    end

    assign winner_o    = winner;
    assign win_valid_o = valid;
    assign period_o    = cnt_first;

endmodule

// File: tb/tb_wta_pwm_ctrl.sv
module tb_wta_pwm_ctrl;

    logic        clk;
    logic        rst;
    logic        ena;
    logic [31:0] level;
    logic [3:0]  pwm_o;
    logic [1:0]  winner_o;
    logic        win_valid_o;
    logic        period_o;

    int total;
    int bad;

    wta_pwm_ctrl #(
        .N_CH (4),
        .W    (8),
        .HYST (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .level       (level),
        .pwm_o       (pwm_o),
        .winner_o    (winner_o),
        .win_valid_o (win_valid_o),
        .period_o    (period_o)
    );

    always #5 clk = ~clk;

    task automatic set_lv(input int a, input int b, input int c, input int d);
        level = {8'(d), 8'(c), 8'(b), 8'(a)};
    endtask

    // Waits (bounded) for the next period_o pulse; n = negedges waited.
    task automatic wait_period(output int n, output bit scan_pwm);
        n = 0;
        scan_pwm = (pwm_o != 4'b0);
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (period_o) break;
            if (pwm_o != 4'b0) scan_pwm = 1'b1;
        end
    endtask

    // Samples one full RUN interval starting at its first cycle.
    task automatic run_period(input int drop_at, output int highs, output int stray,
                              output bit last_hi);
        logic [3:0] mask;
        highs = 0;
        stray = 0;
        last_hi = 1'b0;
        for (int i = 0; i < 256; i++) begin
            if (i == drop_at) ena = 1'b0;
            mask = 4'b0001 << winner_o;
            if ((pwm_o & mask) != 4'b0) highs++;
            if ((pwm_o & ~mask) != 4'b0) stray++;
            if (i == 255) last_hi = ((pwm_o & mask) != 4'b0);
            @(negedge clk);
        end
    endtask

    task automatic stop_run();
        int h, s;
        bit l;
        ena = 1'b0;
        run_period(-1, h, s, l);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ena = 1'b0;
        set_lv(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        total++;
        if ({pwm_o, winner_o, win_valid_o, period_o} !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=00", {pwm_o, winner_o, win_valid_o, period_o});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({pwm_o, win_valid_o, period_o} !== 6'h00) begin
            bad++;
            $display("FAIL idle_after_reset got=%h want=00", {pwm_o, win_valid_o, period_o});
        end
    endtask

    task automatic test_basic();
        int n, h, s;
        bit sp, l;
        set_lv(10, 200, 50, 30);
        ena = 1'b1;
        wait_period(n, sp);
        total++;
        if (n != 5) begin bad++; $display("FAIL basic_first_latency got=%0d want=5", n); end
        total++;
        if (sp) begin bad++; $display("FAIL basic_scan_pwm got=1 want=0"); end
        total++;
        if (winner_o !== 2'd1 || win_valid_o !== 1'b1) begin
            bad++; $display("FAIL basic_winner got=%0d/%0b want=1/1", winner_o, win_valid_o);
        end
        run_period(-1, h, s, l);
        total++;
        if (h != 200) begin bad++; $display("FAIL basic_duty got=%0d want=200", h); end
        total++;
        if (s != 0) begin bad++; $display("FAIL basic_stray got=%0d want=0", s); end
        wait_period(n, sp);
        total++;
        if (n != 4) begin bad++; $display("FAIL basic_period_len got=%0d want=4 (260 total)", n); end
        total++;
        if (sp) begin bad++; $display("FAIL basic_scan2_pwm got=1 want=0"); end
        stop_run();
        total++;
        if ({pwm_o, win_valid_o, period_o} !== 6'h00) begin
            bad++; $display("FAIL basic_stop_idle got=%h want=00", {pwm_o, win_valid_o, period_o});
        end
    endtask

    task automatic test_tie();
        int n, h, s;
        bit sp, l;
        set_lv(90, 90, 20, 20);
        ena = 1'b1;
        wait_period(n, sp);
        total++;
        if (winner_o !== 2'd0) begin bad++; $display("FAIL tie_winner got=%0d want=0", winner_o); end
        run_period(-1, h, s, l);
        total++;
        if (h != 90) begin bad++; $display("FAIL tie_duty got=%0d want=90", h); end
        wait_period(n, sp);
        stop_run();
    endtask

    task automatic test_hysteresis();
        int n, h, s;
        bit sp, l;
        set_lv(10, 100, 50, 20);
        ena = 1'b1;
        wait_period(n, sp);
        total++;
        if (winner_o !== 2'd1) begin bad++; $display("FAIL hyst_init_winner got=%0d want=1", winner_o); end
        set_lv(10, 100, 108, 20);
        run_period(-1, h, s, l);
        wait_period(n, sp);
        total++;
        if (winner_o !== 2'd1) begin bad++; $display("FAIL hyst_108_winner got=%0d want=1", winner_o); end
        set_lv(10, 100, 109, 20);
        run_period(-1, h, s, l);
        total++;
        if (h != 100) begin bad++; $display("FAIL hyst_108_duty got=%0d want=100", h); end
        total++;
        if (winner_o !== 2'd1) begin bad++; $display("FAIL hyst_hold_in_scan got=%0d want=1", winner_o); end
        wait_period(n, sp);
        total++;
        if (winner_o !== 2'd2) begin bad++; $display("FAIL hyst_109_winner got=%0d want=2", winner_o); end
        run_period(-1, h, s, l);
        total++;
        if (h != 109) begin bad++; $display("FAIL hyst_109_duty got=%0d want=109", h); end
        wait_period(n, sp);
        stop_run();
    endtask

    task automatic test_extremes();
        int n, h, s;
        bit sp, l;
        set_lv(0, 0, 0, 0);
        ena = 1'b1;
        wait_period(n, sp);
        set_lv(0, 0, 0, 255);
        run_period(-1, h, s, l);
        total++;
        if (h != 0) begin bad++; $display("FAIL ext_zero_duty got=%0d want=0", h); end
        wait_period(n, sp);
        total++;
        if (winner_o !== 2'd3) begin bad++; $display("FAIL ext_max_winner got=%0d want=3", winner_o); end
        set_lv(255, 0, 0, 250);
        run_period(-1, h, s, l);
        total++;
        if (h != 255 || l != 1'b0) begin
            bad++; $display("FAIL ext_max_duty got=%0d/last=%0b want=255/last=0", h, l);
        end
        wait_period(n, sp);
        total++;
        if (winner_o !== 2'd3) begin bad++; $display("FAIL ext_nowrap_winner got=%0d want=3", winner_o); end
        run_period(-1, h, s, l);
        total++;
        if (h != 250) begin bad++; $display("FAIL ext_nowrap_duty got=%0d want=250", h); end
        wait_period(n, sp);
        stop_run();
    endtask

    task automatic test_ena_drop();
        int n, h, s;
        bit sp, l;
        set_lv(40, 60, 20, 10);
        ena = 1'b1;
        wait_period(n, sp);
        run_period(10, h, s, l);
        total++;
        if (h != 60) begin bad++; $display("FAIL drop_duty got=%0d want=60", h); end
        total++;
        if ({pwm_o, win_valid_o, period_o} !== 6'h00) begin
            bad++; $display("FAIL drop_idle got=%h want=00", {pwm_o, win_valid_o, period_o});
        end
        repeat (3) @(negedge clk);
        total++;
        if ({pwm_o, period_o} !== 5'h00) begin
            bad++; $display("FAIL drop_stay_idle got=%h want=00", {pwm_o, period_o});
        end
        set_lv(55, 50, 20, 10);
        ena = 1'b1;
        wait_period(n, sp);
        total++;
        if (n != 5 || winner_o !== 2'd0) begin
            bad++; $display("FAIL drop_fresh_winner got=%0d/n=%0d want=0/n=5", winner_o, n);
        end
        run_period(-1, h, s, l);
        total++;
        if (h != 55) begin bad++; $display("FAIL drop_fresh_duty got=%0d want=55", h); end
    endtask

    task automatic test_rst_mid();
        int n, h, s;
        bit sp, l;
        wait_period(n, sp);
        repeat (5) @(negedge clk);
        total++;
        if (pwm_o !== 4'b0001) begin bad++; $display("FAIL rst_pre_pwm got=%b want=0001", pwm_o); end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({pwm_o, winner_o, win_valid_o, period_o} !== 8'h00) begin
            bad++; $display("FAIL rst_async got=%h want=00", {pwm_o, winner_o, win_valid_o, period_o});
        end
        ena = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        set_lv(10, 200, 50, 30);
        ena = 1'b1;
        wait_period(n, sp);
        total++;
        if (n != 5 || winner_o !== 2'd1) begin
            bad++; $display("FAIL rst_restart got=%0d/n=%0d want=1/n=5", winner_o, n);
        end
        run_period(-1, h, s, l);
        total++;
        if (h != 200) begin bad++; $display("FAIL rst_restart_duty got=%0d want=200", h); end
        stop_run();
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        ena = 1'b0;
        level = '0;
        total = 0;
        bad = 0;
        test_reset();
        test_basic();
        test_tie();
        test_hysteresis();
        test_extremes();
        test_ena_drop();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
